id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register, directly downstream of the decode-stage control zeroing mux. It captures the (possibly zeroed) control bundle plus decode-stage operands on each clock and presents them to EX. It supports hold (global freeze), flush (taken-branch squash) and bubble tagging (load-use stall). Two saturating counters report inserted bubbles and flushes for performance debug.

Parameters:
DATA_W, 64, width of PC, register operands and immediate
REG_W, 5, register index width
CNT_W, 16, width of bubble/flush counters

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
hold  input  1  freeze: register retains contents
flush  input  1  squash: load a zeroed entry
bubble_in  input  1  stall-select from hazard unit; entry being loaded is a bubble
valid_in  input  1  IF/ID entry valid
ALUOp_in  input  2  ALU operation class
Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in  input  1 each  control bits
pc_in  input  DATA_W  instruction PC
rd1_in, rd2_in  input  DATA_W  register file read data
imm_in  input  DATA_W  sign-extended immediate
funct_in  input  4  {funct7[5], funct3}
rs1_in, rs2_in, rd_in  input  REG_W  register indices
ALUOp_out .. RegWrite_out, pc_out, rd1_out, rd2_out, imm_out, funct_out, rs1_out, rs2_out, rd_out  output  same widths  registered copies of the inputs
valid_out  output  1  EX entry holds a real instruction
bubble_cnt  output  CNT_W  bubbles inserted since reset
flush_cnt  output  CNT_W  flush cycles since reset

Behaviour:
- Single clock domain; every output is a direct register. No combinational input-to-output path. Latency is 1 cycle.
- Reset (sync, high): all outputs 0, including valid_out, both counters and all data fields.
- Per-edge priority: reset > flush > hold > bubble_in > normal load.
- flush=1: all control outputs, valid_out and all data/index fields load 0. flush_cnt increments. flush overrides hold in the same cycle.
- hold=1 (flush=0): every output register retains its value. Counters do not change. bubble_in is ignored.
- bubble_in=1 (no flush or hold): control outputs load 0 regardless of *_in. valid_out loads 0. Data and index fields load their inputs. bubble_cnt increments.
- Normal load: every output loads its input. valid_out loads valid_in.
- Bubbles are defined by bubble_in only. valid_in=0 with bubble_in=0 loads the inputs verbatim and does not count as a bubble.
- Counters saturate at 2^CNT_W-1 and do not wrap. Each counter increments at most once per cycle.
- Reset asserted mid-stream: the next edge clears everything, independent of hold or flush.
- Zero-control guarantee: whenever valid_out=0 due to flush, bubble_in or reset, RegWrite_out, MemWrite_out, MemRead_out and Branch_out are 0.

Test Plan:
- Reset with all inputs driven to 1s -> after one edge, every output and both counters read 0.
- Normal load of pc_in=0x100, rd1_in=5, imm_in=-4, RegWrite_in=1, ALUOp_in=2'b10, rd_in=7, valid_in=1 -> next cycle outputs match exactly, valid_out=1, counters 0.
- bubble_in=1 with MemRead_in=1, RegWrite_in=1, rd_in=3 -> next cycle all control outputs 0, valid_out=0, rd_out=3, bubble_cnt=1.
- hold=1 for 3 cycles while inputs change -> outputs unchanged throughout. Then flush=1 together with hold=1 -> all outputs 0, flush_cnt=1.
- Simultaneous flush=1 and bubble_in=1 -> zeroed entry, flush_cnt increments by 1, bubble_cnt unchanged.
- CNT_W=2, bubble_in held high for 5 cycles -> bubble_cnt reads 1,2,3,3,3 (saturates). A following reset clears it to 0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode-stage control and operands for EX,
// with freeze, squash and load-use bubble handling plus saturating debug counters.
module id_ex_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              bubble_in,
    input  logic              valid_in,
    input  logic [1:0]        ALUOp_in,
    input  logic              Branch_in,
    input  logic              MemRead_in,
    input  logic              MemtoReg_in,
    input  logic              MemWrite_in,
    input  logic              ALUSrc_in,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [3:0]        funct_in,
    input  logic [REG_W-1:0]  rs1_in,
    input  logic [REG_W-1:0]  rs2_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic [1:0]        ALUOp_out,
    output logic              Branch_out,
    output logic              MemRead_out,
    output logic              MemtoReg_out,
    output logic              MemWrite_out,
    output logic              ALUSrc_out,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [3:0]        funct_out,
    output logic [REG_W-1:0]  rs1_out,
    output logic [REG_W-1:0]  rs2_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic bubbleSat;
    logic flushSat;

    assign bubbleSat = (bubble_cnt == CNT_MAX);
    assign flushSat  = (flush_cnt == CNT_MAX);

    // Control bits and valid: a bubble keeps the operands but kills every side effect.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ALUOp_out    <= '0;
            Branch_out   <= 1'b0;
            MemRead_out  <= 1'b0;
            MemtoReg_out <= 1'b0;
            MemWrite_out <= 1'b0;
            ALUSrc_out   <= 1'b0;
            RegWrite_out <= 1'b0;
            valid_out    <= 1'b0;
        end else if (!hold) begin
            if (bubble_in) begin
                ALUOp_out    <= '0;
                Branch_out   <= 1'b0;
                MemRead_out  <= 1'b0;
                MemtoReg_out <= 1'b0;
                MemWrite_out <= 1'b0;
                ALUSrc_out   <= 1'b0;
                RegWrite_out <= 1'b0;
                valid_out    <= 1'b0;
            end else begin
                ALUOp_out    <= ALUOp_in;
                Branch_out   <= Branch_in;
                MemRead_out  <= MemRead_in;
                MemtoReg_out <= MemtoReg_in;
                MemWrite_out <= MemWrite_in;
                ALUSrc_out   <= ALUSrc_in;
                RegWrite_out <= RegWrite_in;
                valid_out    <= valid_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pc_out    <= '0;
            rd1_out   <= '0;
            rd2_out   <= '0;
            imm_out   <= '0;
            funct_out <= '0;
            rs1_out   <= '0;
            rs2_out   <= '0;
            rd_out    <= '0;
        end else if (!hold) begin
            pc_out    <= pc_in;
            rd1_out   <= rd1_in;
            rd2_out   <= rd2_in;
            imm_out   <= imm_in;
            funct_out <= funct_in;
            rs1_out   <= rs1_in;
            rs2_out   <= rs2_in;
            rd_out    <= rd_in;
        end
    end

    // A flush wins over a coincident bubble, so only one counter can move per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            if (!flushSat) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end else if (!hold && bubble_in && !bubbleSat) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, a narrow-counter saturation
// sequence, and randomized traffic checked against a rule-level model.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        reset, hold, flush, bubble, valid;
        logic [1:0]  aluOp;
        logic        branch, memRead, memtoReg, memWrite, aluSrc, regWrite;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  funct;
        logic [4:0]  rs1, rs2, rd;
    } StimRec;

    typedef struct packed {
        logic [1:0]  aluOp;
        logic        branch, memRead, memtoReg, memWrite, aluSrc, regWrite, valid;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  funct;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] bubbleCnt, flushCnt;
    } OutRec;

    typedef struct {
        string  name;
        StimRec stim;
        OutRec  want;
    } VecRec;

    logic        clk = 1'b0;
    logic        reset, hold, flush, bubble_in, valid_in;
    logic [1:0]  ALUOp_in;
    logic        Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in;
    logic [63:0] pc_in, rd1_in, rd2_in, imm_in;
    logic [3:0]  funct_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;

    logic [1:0]  ALUOp_out;
    logic        Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out, RegWrite_out;
    logic [63:0] pc_out, rd1_out, rd2_out, imm_out;
    logic [3:0]  funct_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic        valid_out;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        smallReset, smallHold, smallFlush, smallBubble;
    logic [1:0]  sALUOp;
    logic        sBranch, sMemRead, sMemtoReg, sMemWrite, sALUSrc, sRegWrite, sValid;
    logic [63:0] sPc, sRd1, sRd2, sImm;
    logic [3:0]  sFunct;
    logic [4:0]  sRs1, sRs2, sRd;
    logic [1:0]  sBubbleCnt, sFlushCnt;

    OutRec got;
    int    checkCount = 0;
    int    passCount  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .bubble_in(bubble_in), .valid_in(valid_in), .ALUOp_in(ALUOp_in),
        .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in),
        .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .RegWrite_in(RegWrite_in),
        .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .funct_in(funct_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .ALUOp_out(ALUOp_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
        .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out), .ALUSrc_out(ALUSrc_out),
        .RegWrite_out(RegWrite_out), .pc_out(pc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
        .imm_out(imm_out), .funct_out(funct_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rd_out(rd_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dutSmall (
        .clk(clk), .reset(smallReset), .hold(smallHold), .flush(smallFlush),
        .bubble_in(smallBubble), .valid_in(valid_in), .ALUOp_in(ALUOp_in),
        .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in),
        .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .RegWrite_in(RegWrite_in),
        .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .funct_in(funct_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .ALUOp_out(sALUOp), .Branch_out(sBranch), .MemRead_out(sMemRead),
        .MemtoReg_out(sMemtoReg), .MemWrite_out(sMemWrite), .ALUSrc_out(sALUSrc),
        .RegWrite_out(sRegWrite), .pc_out(sPc), .rd1_out(sRd1), .rd2_out(sRd2),
        .imm_out(sImm), .funct_out(sFunct), .rs1_out(sRs1), .rs2_out(sRs2),
        .rd_out(sRd), .valid_out(sValid), .bubble_cnt(sBubbleCnt), .flush_cnt(sFlushCnt)
    );

    assign got = {ALUOp_out, Branch_out, MemRead_out, MemtoReg_out, MemWrite_out,
                  ALUSrc_out, RegWrite_out, valid_out, pc_out, rd1_out, rd2_out,
                  imm_out, funct_out, rs1_out, rs2_out, rd_out, bubble_cnt, flush_cnt};

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (int'(v) + 1 > 65535) ? v : v + 16'd1;
    endfunction

    // Entry that simply mirrors the instruction being presented, counters zero.
    function automatic OutRec passThrough(input StimRec s);
        OutRec r;
        r = '0;
        r.aluOp = s.aluOp;   r.branch = s.branch;     r.memRead = s.memRead;
        r.memtoReg = s.memtoReg; r.memWrite = s.memWrite; r.aluSrc = s.aluSrc;
        r.regWrite = s.regWrite; r.valid = s.valid;
        r.pc = s.pc; r.rd1 = s.rd1; r.rd2 = s.rd2; r.imm = s.imm;
        r.funct = s.funct; r.rs1 = s.rs1; r.rs2 = s.rs2; r.rd = s.rd;
        return r;
    endfunction

    // Reference: what EX should see after one edge, straight from the priority rules.
    function automatic OutRec modelStep(input OutRec cur, input StimRec s);
        OutRec r;
        if (s.reset) begin
            r = '0;
        end else if (s.flush) begin
            r = '0;
            r.bubbleCnt = cur.bubbleCnt;
            r.flushCnt  = satInc(cur.flushCnt);
        end else if (s.hold) begin
            r = cur;
        end else begin
            r = passThrough(s);
            r.flushCnt  = cur.flushCnt;
            r.bubbleCnt = cur.bubbleCnt;
            if (s.bubble) begin
                r.aluOp = 2'b00; r.branch = 0; r.memRead = 0; r.memtoReg = 0;
                r.memWrite = 0; r.aluSrc = 0; r.regWrite = 0; r.valid = 0;
                r.bubbleCnt = satInc(cur.bubbleCnt);
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input StimRec s);
        reset = s.reset; hold = s.hold; flush = s.flush; bubble_in = s.bubble;
        valid_in = s.valid; ALUOp_in = s.aluOp; Branch_in = s.branch;
        MemRead_in = s.memRead; MemtoReg_in = s.memtoReg; MemWrite_in = s.memWrite;
        ALUSrc_in = s.aluSrc; RegWrite_in = s.regWrite;
        pc_in = s.pc; rd1_in = s.rd1; rd2_in = s.rd2; imm_in = s.imm;
        funct_in = s.funct; rs1_in = s.rs1; rs2_in = s.rs2; rd_in = s.rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input OutRec want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    endtask

    task automatic checkSmall(input string name, input logic [1:0] wantB, input logic [1:0] wantF);
        checkCount++;
        if (sBubbleCnt === wantB && sFlushCnt === wantF) passCount++;
        else $display("[TB] FAIL %s got bubble=%0d flush=%0d want bubble=%0d flush=%0d",
                      name, sBubbleCnt, sFlushCnt, wantB, wantF);
    endtask

    task automatic smallStep(input logic r, input logic h, input logic f, input logic b);
        smallReset = r; smallHold = h; smallFlush = f; smallBubble = b;
        @(posedge clk);
        #1;
    endtask

    VecRec  tbl[$];
    StimRec s;
    OutRec  w;
    OutRec  afterBubble;
    OutRec  model;

    initial begin
        smallReset = 1'b1; smallHold = 1'b0; smallFlush = 1'b0; smallBubble = 1'b0;

        s = '1;  w = '0;
        tbl.push_back('{"resetOnes", s, w});

        s = '0; s.pc = 64'h100; s.rd1 = 64'd5; s.imm = 64'hFFFF_FFFF_FFFF_FFFC;
        s.regWrite = 1; s.aluOp = 2'b10; s.rd = 5'd7; s.valid = 1;
        w = '0; w.pc = 64'h100; w.rd1 = 64'd5; w.imm = 64'hFFFF_FFFF_FFFF_FFFC;
        w.regWrite = 1; w.aluOp = 2'b10; w.rd = 5'd7; w.valid = 1;
        tbl.push_back('{"normalLoad", s, w});

        s = '0; s.bubble = 1; s.memRead = 1; s.regWrite = 1; s.rd = 5'd3;
        s.valid = 1; s.pc = 64'h104; s.aluOp = 2'b01; s.rs1 = 5'd1;
        w = '0; w.rd = 5'd3; w.pc = 64'h104; w.rs1 = 5'd1; w.bubbleCnt = 16'd1;
        afterBubble = w;
        tbl.push_back('{"bubble", s, w});

        for (int k = 0; k < 3; k++) begin
            s = '0; s.hold = 1; s.pc = 64'h200 + 64'(k); s.regWrite = 1; s.valid = 1;
            s.rd = 5'(k + 10); s.rd1 = 64'hABCD_0000 + 64'(k); s.bubble = (k == 1);
            tbl.push_back('{$sformatf("hold%0d", k), s, afterBubble});
        end

        s = '0; s.flush = 1; s.hold = 1; s.regWrite = 1; s.valid = 1; s.pc = 64'h300;
        w = '0; w.bubbleCnt = 16'd1; w.flushCnt = 16'd1;
        tbl.push_back('{"flushOverHold", s, w});

        s = '0; s.flush = 1; s.bubble = 1; s.memWrite = 1; s.valid = 1; s.rd = 5'd4;
        w = '0; w.bubbleCnt = 16'd1; w.flushCnt = 16'd2;
        tbl.push_back('{"flushPlusBubble", s, w});

        s = '0; s.valid = 0; s.regWrite = 1; s.memWrite = 1; s.rd = 5'd9;
        s.pc = 64'h400; s.rd2 = 64'hDEAD;
        w = passThrough(s); w.bubbleCnt = 16'd1; w.flushCnt = 16'd2;
        tbl.push_back('{"invalidNoBubble", s, w});

        s = '0; s.valid = 1; s.aluOp = 2'b11; s.branch = 1; s.memRead = 1; s.memtoReg = 1;
        s.memWrite = 1; s.aluSrc = 1; s.regWrite = 1; s.pc = 64'h8000_0000_0000_0010;
        s.rd1 = 64'h1234_5678_9ABC_DEF0; s.rd2 = 64'h0FED_CBA9_8765_4321;
        s.imm = 64'h7FFF; s.funct = 4'hA; s.rs1 = 5'd31; s.rs2 = 5'd17; s.rd = 5'd30;
        w = passThrough(s); w.bubbleCnt = 16'd1; w.flushCnt = 16'd2;
        tbl.push_back('{"allFieldsLoad", s, w});

        s = '0; s.reset = 1; s.hold = 1; s.flush = 1; s.bubble = 1; s.valid = 1;
        s.regWrite = 1; s.pc = 64'h500;
        w = '0;
        tbl.push_back('{"resetMidStream", s, w});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].stim);
            checkOutput(tbl[i].name, tbl[i].want);
        end

        // Narrow counters: saturation and reset recovery.
        smallStep(1, 0, 0, 0);
        checkSmall("smallReset", 2'd0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            smallStep(0, 0, 0, 1);
            checkSmall($sformatf("smallBubble%0d", k), (k < 3) ? 2'(k + 1) : 2'd3, 2'd0);
        end
        smallStep(0, 1, 0, 1);
        checkSmall("smallHoldBubble", 2'd3, 2'd0);
        for (int k = 0; k < 4; k++) begin
            smallStep(0, 0, 1, 0);
            checkSmall($sformatf("smallFlush%0d", k), 2'd3, (k < 3) ? 2'(k + 1) : 2'd3);
        end
        smallStep(1, 1, 1, 1);
        checkSmall("smallReclear", 2'd0, 2'd0);

        model = '0;
        for (int i = 0; i < 400; i++) begin
            s.reset    = (i == 0) || ($urandom_range(0, 49) == 0);
            s.flush    = ($urandom_range(0, 9) == 0);
            s.hold     = ($urandom_range(0, 6) == 0);
            s.bubble   = ($urandom_range(0, 4) == 0);
            s.valid    = 1'($urandom);
            s.aluOp    = 2'($urandom);
            s.branch   = 1'($urandom); s.memRead  = 1'($urandom);
            s.memtoReg = 1'($urandom); s.memWrite = 1'($urandom);
            s.aluSrc   = 1'($urandom); s.regWrite = 1'($urandom);
            s.pc  = {$urandom, $urandom}; s.rd1 = {$urandom, $urandom};
            s.rd2 = {$urandom, $urandom}; s.imm = {$urandom, $urandom};
            s.funct = 4'($urandom); s.rs1 = 5'($urandom);
            s.rs2 = 5'($urandom);   s.rd = 5'($urandom);
            model = modelStep(model, s);
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", i), model);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
